// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory/IO access controller.
package lc3_mem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StDone
  } mem_state_t;

  localparam logic [15:0] IO_ADDR_DFLT = 16'hFFFF;

  // States during which the SRAM write address/data come from the latches.
  function automatic logic is_wr_state(mem_state_t s);
    return (s == StWrSetup) || (s == StWrPulse) || (s == StWrHold);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable 3-bit down-counter that paces SRAM read and write-pulse phases.
module mem_wait_timer (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       en,
  output logic       zero
);

  logic [2:0] cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= 3'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != 3'd0)) begin
      cnt_q <= cnt_q - 3'd1;
    end
  end

  assign zero = (cnt_q == 3'd0);

endmodule

// File: rtl/mem_io_ctrl.sv
// Sequences LC-3 memory strobes onto an async SRAM and decodes the switch/hex IO location.
module mem_io_ctrl
  import lc3_mem_pkg::*;
#(
  parameter logic [15:0] IO_ADDR     = IO_ADDR_DFLT,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned SRAM_AW     = 20
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Mem_CE,
  input  logic               Mem_OE,
  input  logic               Mem_WE,
  input  logic [15:0]        MAR,
  input  logic [15:0]        MDR,
  input  logic [15:0]        Switches,
  input  logic [15:0]        SRAM_DQ_in,
  output logic [15:0]        SRAM_DQ_out,
  output logic               SRAM_DQ_oe,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic [15:0]        Data_to_CPU,
  output logic [15:0]        Hex_Data,
  output logic               Mem_Ready
);

  // Timer holds (cycles - 1) so that a zero count means the last phase cycle is running.
  localparam logic [2:0] TimerLoad = 3'(WAIT_STATES - 1);

  mem_state_t  state_q, state_d;
  logic        we_n_q, dq_oe_q, ready_q, ready_d;
  logic [15:0] hex_q, addr_q, data_q;
  logic        latch_wr, hex_we;
  logic        tmr_load, tmr_en, tmr_zero;
  logic        io_hit;

  assign io_hit = (MAR == IO_ADDR);

  mem_wait_timer u_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (tmr_load),
    .load_val (TimerLoad),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    ready_d  = 1'b0;
    latch_wr = 1'b0;
    hex_we   = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A write strobe takes priority over a simultaneous read strobe.
        if (!Mem_WE) begin
          if (io_hit) begin
            hex_we  = 1'b1;
            ready_d = 1'b1;
            state_d = StDone;
          end else begin
            latch_wr = 1'b1;
            state_d  = StWrSetup;
          end
        end else if (!Mem_OE) begin
          tmr_load = 1'b1;
          state_d  = StRd;
        end
      end
      StRd: begin
        if (Mem_OE) begin
          state_d = StIdle;
        end else if (tmr_zero) begin
          ready_d = 1'b1;
          state_d = StDone;
        end else begin
          tmr_en = 1'b1;
        end
      end
      StWrSetup: begin
        tmr_load = 1'b1;
        state_d  = StWrPulse;
      end
      StWrPulse: begin
        // Release only counts as an abort while pulse cycles remain.
        if (tmr_zero) begin
          ready_d = 1'b1;
          state_d = StWrHold;
        end else if (Mem_WE) begin
          state_d = StWrHold;
        end else begin
          tmr_en = 1'b1;
        end
      end
      StWrHold: begin
        state_d = StDone;
      end
      StDone: begin
        if (Mem_OE && Mem_WE) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // WE_N and DQ_oe are registered from the next state so the pins never glitch.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      we_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
      ready_q <= 1'b0;
      hex_q   <= 16'h0000;
      addr_q  <= 16'h0000;
      data_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      we_n_q  <= (state_d != StWrPulse);
      dq_oe_q <= is_wr_state(state_d);
      ready_q <= ready_d;
      if (latch_wr) begin
        addr_q <= MAR;
        data_q <= MDR;
      end
      if (hex_we) begin
        hex_q <= MDR;
      end
    end
  end

  assign Data_to_CPU = io_hit ? Switches : SRAM_DQ_in;
  assign SRAM_OE_N   = Mem_OE | io_hit | Mem_CE;
  assign SRAM_CE_N   = Mem_CE;
  assign SRAM_UB_N   = Mem_CE;
  assign SRAM_LB_N   = Mem_CE;
  assign SRAM_ADDR   = SRAM_AW'(is_wr_state(state_q) ? addr_q : MAR);
  assign SRAM_DQ_out = data_q;
  assign SRAM_DQ_oe  = dq_oe_q;
  assign SRAM_WE_N   = we_n_q;
  assign Hex_Data    = hex_q;
  assign Mem_Ready   = ready_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Scoreboard bench for mem_io_ctrl: Ready pulses are matched against predicted cycles.
module tb_mem_io_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Mem_CE, Mem_OE, Mem_WE;
  logic [15:0] MAR, MDR, Switches, SRAM_DQ_in;
  logic [15:0] SRAM_DQ_out, Data_to_CPU, Hex_Data;
  logic        SRAM_DQ_oe, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, Mem_Ready;
  logic [19:0] SRAM_ADDR;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int sb[$];

  mem_io_ctrl #(
    .IO_ADDR     (16'hFFFF),
    .WAIT_STATES (1),
    .SRAM_AW     (20)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Mem_CE      (Mem_CE),
    .Mem_OE      (Mem_OE),
    .Mem_WE      (Mem_WE),
    .MAR         (MAR),
    .MDR         (MDR),
    .Switches    (Switches),
    .SRAM_DQ_in  (SRAM_DQ_in),
    .SRAM_DQ_out (SRAM_DQ_out),
    .SRAM_DQ_oe  (SRAM_DQ_oe),
    .SRAM_ADDR   (SRAM_ADDR),
    .SRAM_CE_N   (SRAM_CE_N),
    .SRAM_OE_N   (SRAM_OE_N),
    .SRAM_WE_N   (SRAM_WE_N),
    .SRAM_UB_N   (SRAM_UB_N),
    .SRAM_LB_N   (SRAM_LB_N),
    .Data_to_CPU (Data_to_CPU),
    .Hex_Data    (Hex_Data),
    .Mem_Ready   (Mem_Ready)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Every Ready pulse must match the oldest predicted completion cycle.
  always @(negedge Clk) begin
    if (Mem_Ready !== 1'b0) begin
      if (sb.size() == 0) begin
        check_eq("ready_unexp", 32'(Mem_Ready), 32'd0);
      end else begin
        check_eq("ready_cyc", cyc, sb.pop_front());
      end
    end
  end

  task automatic sync();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_read(input logic [15:0] a, input logic [15:0] din, input logic [15:0] sw,
                         input logic [15:0] exp_data, input logic exp_oen);
    sync();
    MAR = a; SRAM_DQ_in = din; Switches = sw; Mem_CE = 1'b0; Mem_OE = 1'b0;
    sb.push_back(cyc + 2);
    #1;
    check_eq("rd_data_now", Data_to_CPU, exp_data);
    check_eq("rd_oe_n_now", SRAM_OE_N, exp_oen);
    for (int i = 0; i <= 3; i++) begin
      @(negedge Clk);
      if (i <= 2) check_eq("rd_oe_n", SRAM_OE_N, exp_oen);
      if (i == 2) begin
        Mem_OE = 1'b1; Mem_CE = 1'b1;
      end
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic oe_too);
    int low = 0;
    sync();
    MAR = a; MDR = d; Mem_CE = 1'b0; Mem_WE = 1'b0;
    if (oe_too) Mem_OE = 1'b0;
    sb.push_back(cyc + 3);
    for (int i = 0; i <= 5; i++) begin
      @(negedge Clk);
      if (!SRAM_WE_N) low++;
      check_eq("wr_dq_oe", SRAM_DQ_oe, 32'((i >= 1) && (i <= 3)));
      if (i >= 1 && i <= 3) begin
        check_eq("wr_dq_out", SRAM_DQ_out, d);
        check_eq("wr_addr", SRAM_ADDR, {4'h0, a});
      end
      if (i == 2) begin
        check_eq("wr_pulse_we_n", SRAM_WE_N, 32'd0);
        Mem_WE = 1'b1; Mem_OE = 1'b1; Mem_CE = 1'b1;
        MAR = 16'h0999; MDR = 16'h1111;
      end
    end
    check_eq("wr_we_low_cycles", low, 32'd1);
  endtask

  task automatic do_io_write(input logic [15:0] d, input logic [15:0] prev);
    int low = 0;
    sync();
    MAR = 16'hFFFF; MDR = d; Mem_CE = 1'b0; Mem_WE = 1'b0;
    sb.push_back(cyc + 1);
    check_eq("io_hex_before", Hex_Data, prev);
    for (int i = 0; i <= 4; i++) begin
      @(negedge Clk);
      if (!SRAM_WE_N) low++;
      if (i >= 1) check_eq("io_hex", Hex_Data, d);
      if (i == 2) begin
        Mem_WE = 1'b1; Mem_CE = 1'b1;
      end
    end
    check_eq("io_we_low_cycles", low, 32'd0);
  endtask

  initial begin
    Reset = 1'b1; Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
    MAR = 16'h0000; MDR = 16'h0000; Switches = 16'h0000; SRAM_DQ_in = 16'h0000;
    repeat (2) sync();
    Reset = 1'b0;
    repeat (3) sync();
    @(negedge Clk);
    check_eq("rst_hex", Hex_Data, 32'h0);
    check_eq("rst_we_n", SRAM_WE_N, 32'd1);
    check_eq("rst_dq_oe", SRAM_DQ_oe, 32'd0);
    check_eq("rst_ready", Mem_Ready, 32'd0);
    check_eq("rst_dq_out", SRAM_DQ_out, 32'h0);

    do_read(16'h0010, 16'h1234, 16'h5A5A, 16'h1234, 1'b0);
    do_read(16'hFFFF, 16'h1234, 16'hBEEF, 16'hBEEF, 1'b1);
    do_write(16'h0020, 16'hCAFE, 1'b0);
    do_io_write(16'h00A5, 16'h0000);
    do_write(16'h0050, 16'h7777, 1'b1);

    // Read abandoned after one cycle: no Ready pulse may follow.
    sync();
    MAR = 16'h0060; SRAM_DQ_in = 16'h4321; Mem_CE = 1'b0; Mem_OE = 1'b0;
    @(negedge Clk);
    check_eq("rd_abort_oe_n", SRAM_OE_N, 32'd0);
    @(negedge Clk);
    Mem_OE = 1'b1; Mem_CE = 1'b1;
    repeat (3) sync();

    // Reset lands while the write pulse is active.
    sync();
    MAR = 16'h0030; MDR = 16'h5555; Mem_CE = 1'b0; Mem_WE = 1'b0;
    repeat (3) @(negedge Clk);
    check_eq("rstw_pulse_we_n", SRAM_WE_N, 32'd0);
    Reset = 1'b1; MAR = 16'h0040;
    @(negedge Clk);
    check_eq("rstw_we_n", SRAM_WE_N, 32'd1);
    check_eq("rstw_dq_oe", SRAM_DQ_oe, 32'd0);
    check_eq("rstw_addr_idle", SRAM_ADDR, 32'h00040);
    check_eq("rstw_dq_out", SRAM_DQ_out, 32'h0);
    check_eq("rstw_hex", Hex_Data, 32'h0);
    Reset = 1'b0; Mem_WE = 1'b1; Mem_CE = 1'b1;
    repeat (4) sync();

    check_eq("sb_left", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_io_ctrl.md
# mem_io_ctrl

Memory/IO access controller that sits directly downstream of the LC-3 control unit's memory strobes (Mem_CE/OE/WE, active-low) and the MAR/MDR registers. It drives the off-chip 16-bit asynchronous SRAM with properly sequenced setup, pulse and hold phases. It maps address IO_ADDR to a switch input (read) and a hex-display register (write). It also returns read data to the MDR input mux and raises a completion pulse for future wait-state-aware control.

## Interface
- IO_ADDR, 16'hFFFF, memory-mapped IO address (switches on read, hex register on write)
- WAIT_STATES, 1, SRAM cycles per access phase (range 1..7)
- SRAM_AW, 20, SRAM address width; upper bits above 16 are tied to 0

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- Mem_CE  in  1  active-low chip enable from control unit
- Mem_OE  in  1  active-low read strobe from control unit
- Mem_WE  in  1  active-low write strobe from control unit
- MAR  in  16  access address
- MDR  in  16  write data
- Switches  in  16  IO read value
- SRAM_DQ_in  in  16  data from SRAM pins
- SRAM_DQ_out  out  16  data to SRAM pins
- SRAM_DQ_oe  out  1  pin output enable; 1 = drive
- SRAM_ADDR  out  SRAM_AW  SRAM address
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  SRAM controls
- Data_to_CPU  out  16  read data to MDR mux
- Hex_Data  out  16  hex-display register
- Mem_Ready  out  1  one-cycle access-complete pulse

## Operation
- Reset values:
  - state IDLE; Hex_Data 0; Mem_Ready 0; SRAM_WE_N 1; SRAM_DQ_oe 0; SRAM_DQ_out 0; latched address 0.
- Read path (combinational, zero latency, so the 2-cycle fetch timing is unchanged):
  - io_hit = (MAR == IO_ADDR).
  - Data_to_CPU = io_hit ? Switches : SRAM_DQ_in.
  - SRAM_OE_N = Mem_OE | io_hit | Mem_CE.
- SRAM_CE_N = Mem_CE. UB_N/LB_N = Mem_CE (word accesses only).
- SRAM_ADDR:
  - in write states: the latched address, zero-extended;
  - otherwise: MAR, zero-extended.
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE:
  - Mem_WE=0 & ~io_hit: latch MAR and MDR, go to WR_SETUP.
  - Mem_WE=0 & io_hit: Hex_Data <= MDR at this edge, pulse Mem_Ready, go to DONE.
  - Mem_OE=0 (WE=1): go to RD.
  - WE and OE both low: the write wins and the read is ignored.
- RD:
  - Count WAIT_STATES cycles of continuous OE=0, then pulse Mem_Ready and go to DONE.
  - OE released early: go to IDLE with no Ready pulse.
- WR_SETUP: exactly one cycle; DQ_oe=1, WE_N=1.
- WR_PULSE:
  - WE_N=0 and DQ_oe=1 for WAIT_STATES cycles, then go to WR_HOLD.
  - Mem_WE released early: abort to WR_HOLD (WE_N high on the next cycle).
- WR_HOLD: one cycle; DQ_oe=1, WE_N=1. Mem_Ready pulses only if the pulse completed. Then go to DONE.
- DONE: wait until Mem_OE=Mem_WE=1, then go to IDLE. This prevents a held strobe from re-triggering.
- SRAM_WE_N and SRAM_DQ_oe are registered outputs, so they are glitch-free.
- SRAM_DQ_out is the latched MDR value, stable from WR_SETUP through WR_HOLD.
- The address comparison is done on the full 16 bits; no wrap-around aliasing.

## Timing
- Write, WAIT_STATES=1, strobe first seen low at edge k:
  - cycle k+1: SETUP
  - cycle k+2: PULSE (WE_N=0)
  - cycle k+3: HOLD, Mem_Ready=1
  - cycle k+4: DONE or IDLE
- Write timing matches a 2-state WE strobe. The HOLD cycle overlaps the next fetch; it is safe because the address is latched.
- Read: Data_to_CPU is valid in the same cycle as MAR (combinational). Mem_Ready is high in cycle k+WAIT_STATES+1.
- IO write: Hex_Data updates at edge k. Mem_Ready is high in cycle k+1.
- Reset mid-write: WE_N=1 and DQ_oe=0 from the cycle after the reset edge.

## Structure
- Package lc3_mem_pkg holds:
  - the state enum (mem_state_t);
  - the default IO_ADDR constant.
- Sub-module mem_wait_timer: loadable 3-bit down-counter with load, enable and a zero flag; used by both RD and WR_PULSE.

## Test plan
- Reset, then hold idle: Hex_Data=0, SRAM_WE_N=1, DQ_oe=0, Mem_Ready=0.
- Read, MAR=0x0010, SRAM_DQ_in=0x1234, OE low 2 cycles: Data_to_CPU=0x1234 in the same cycle; SRAM_OE_N=0; one Ready pulse.
- Read, MAR=0xFFFF, Switches=0xBEEF: Data_to_CPU=0xBEEF; SRAM_OE_N stays 1.
- Write, MAR=0x0020, MDR=0xCAFE, WE low 2 cycles: DQ_out=0xCAFE across SETUP/PULSE/HOLD; exactly one WE_N low cycle; addr=0x00020.
- Write to MAR=0xFFFF, MDR=0x00A5: Hex_Data=0x00A5 one edge later; SRAM_WE_N never low.
- Reset asserted during WR_PULSE: WE_N=1 and DQ_oe=0 next cycle; state IDLE; no Ready pulse.
